// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller: forward-select
// encodings, memory-handshake FSM states and the watchdog timer width.
package pipeline_pkg;

    // Operand source selects driven towards the E-stage ALU input muxes
    localparam logic [1:0] FWD_RF = 2'b00;  // value read from the register file
    localparam logic [1:0] FWD_W  = 2'b01;  // ResultW from the writeback stage
    localparam logic [1:0] FWD_M  = 2'b10;  // ALUOutM from the memory stage

    // Data-memory handshake tracker
    typedef enum logic [1:0] {
        IDLE = 2'b00,   // no outstanding access
        WAIT = 2'b01,   // M-stage access waiting for mem_ready_m
        ERR  = 2'b10    // watchdog expired, pipeline frozen until reset
    } mem_state_t;

    // Width of the WAIT-cycle timer; MEM_TIMEOUT must fit in it
    localparam int TIMER_W = 16;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Bundle of pipeline stage information flowing into the hazard controller and
// the stall/flush/forward controls flowing back to the stage registers.
// The controller side uses the slave modport, the pipeline side the master.
interface pipeline_hazard_ctrl_if #(
    parameter int REG_AW = 5
);
    // D-stage operand usage
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic              rs1_used_d;
    logic              rs2_used_d;

    // E-stage sources and per-stage destinations
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic [REG_AW-1:0] rd_m;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_e;
    logic              reg_write_m;
    logic              reg_write_w;
    logic              mem_read_e;
    logic              pc_src_e;

    // M-stage data-memory handshake
    logic              mem_req_m;
    logic              mem_ready_m;

    // Stage controls
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              stall_m;
    logic              flush_d;
    logic              flush_e;
    logic              flush_w;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;

    // Pipeline side: publishes stage state, consumes controls
    modport master (
        output rs1_d, rs2_d, rs1_used_d, rs2_used_d,
        output rs1_e, rs2_e, rd_e, rd_m, rd_w,
        output reg_write_e, reg_write_m, reg_write_w, mem_read_e, pc_src_e,
        output mem_req_m, mem_ready_m,
        input  stall_f, stall_d, stall_e, stall_m,
        input  flush_d, flush_e, flush_w,
        input  forward_a_e, forward_b_e
    );

    // Controller side: consumes stage state, produces controls
    modport slave (
        input  rs1_d, rs2_d, rs1_used_d, rs2_used_d,
        input  rs1_e, rs2_e, rd_e, rd_m, rd_w,
        input  reg_write_e, reg_write_m, reg_write_w, mem_read_e, pc_src_e,
        input  mem_req_m, mem_ready_m,
        output stall_f, stall_d, stall_e, stall_m,
        output flush_d, flush_e, flush_w,
        output forward_a_e, forward_b_e
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forward-select generator for one E-stage source register. The memory stage
// holds the younger result, so a match there beats a match in writeback.
// Register x0 is hard-wired to zero and is never forwarded.
module fwd_select
    import pipeline_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [REG_AW-1:0] src,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              reg_write_m,
    input  logic              reg_write_w,
    output logic [1:0]        sel
);

    logic hit_m;
    logic hit_w;

    assign hit_m = reg_write_m && (rd_m != '0) && (rd_m == src);
    assign hit_w = reg_write_w && (rd_w != '0) && (rd_w == src);

    // Priority select: M over W over register file
    always_comb begin
        // NOTE: sel gets a value before any branch so every path assigns it
        // and no latch is inferred.
        sel = FWD_RF;
        if (hit_m) begin
            sel = FWD_M;
        end else if (hit_w) begin
            sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32 pipeline. Produces every stall,
// flush and forward select from same-cycle stage information plus the state
// of a small data-memory handshake tracker. Only the tracker state, its WAIT
// timer and the two saturating perf counters are registered.
module pipeline_hazard_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter bit FWD_EN      = 1'b1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    pipeline_hazard_ctrl_if.slave hz,
    output logic                  mem_timeout,
    output logic [CNT_W-1:0]      stall_cnt,
    output logic [CNT_W-1:0]      flush_cnt
);

    localparam logic [TIMER_W-1:0] TIMEOUT_VAL = TIMER_W'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

    mem_state_t           state;
    mem_state_t           state_nxt;
    logic [TIMER_W-1:0]   timer;
    logic [TIMER_W-1:0]   timer_nxt;

    logic                 mem_stall;
    logic                 load_use;
    logic                 raw_stall;
    logic                 hazard;
    logic                 front_stall;
    logic [1:0]           fwd_a;
    logic [1:0]           fwd_b;

    // A used D-stage source that a writing stage will overwrite (x0 excluded)
    function automatic logic src_hit(
        input logic              used,
        input logic [REG_AW-1:0] src,
        input logic              wr,
        input logic [REG_AW-1:0] rd
    );
        return used && wr && (rd != '0) && (src == rd);
    endfunction

    // ------------------------------------------------------------------
    // Forwarding selects for both ALU operands
    // ------------------------------------------------------------------
    fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
        .src         (hz.rs1_e),
        .rd_m        (hz.rd_m),
        .rd_w        (hz.rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .sel         (fwd_a)
    );

    fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
        .src         (hz.rs2_e),
        .rd_m        (hz.rd_m),
        .rd_w        (hz.rd_w),
        .reg_write_m (hz.reg_write_m),
        .reg_write_w (hz.reg_write_w),
        .sel         (fwd_b)
    );

    // ------------------------------------------------------------------
    // Data hazards seen from the D stage
    // ------------------------------------------------------------------
    // With forwarding only a load in E is too late to bypass; without it
    // any in-flight writer of a used source holds D until it retires.
    assign load_use  = hz.mem_read_e &&
                       (src_hit(hz.rs1_used_d, hz.rs1_d, hz.reg_write_e, hz.rd_e) ||
                        src_hit(hz.rs2_used_d, hz.rs2_d, hz.reg_write_e, hz.rd_e));

    assign raw_stall = src_hit(hz.rs1_used_d, hz.rs1_d, hz.reg_write_e, hz.rd_e) ||
                       src_hit(hz.rs2_used_d, hz.rs2_d, hz.reg_write_e, hz.rd_e) ||
                       src_hit(hz.rs1_used_d, hz.rs1_d, hz.reg_write_m, hz.rd_m) ||
                       src_hit(hz.rs2_used_d, hz.rs2_d, hz.reg_write_m, hz.rd_m) ||
                       src_hit(hz.rs1_used_d, hz.rs1_d, hz.reg_write_w, hz.rd_w) ||
                       src_hit(hz.rs2_used_d, hz.rs2_d, hz.reg_write_w, hz.rd_w);

    assign hazard    = FWD_EN ? load_use : raw_stall;

    // ------------------------------------------------------------------
    // Memory handshake tracker
    // ------------------------------------------------------------------
    // Tracker state and WAIT timer register
    always_ff @(posedge clk) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples the pre-edge values regardless of block ordering.
        if (rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    // Next-state, timer update and memory stall request
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        mem_stall = 1'b0;
        case (state)
            IDLE: begin
                if (hz.mem_req_m && !hz.mem_ready_m) begin
                    mem_stall = 1'b1;
                    state_nxt = WAIT;
                    timer_nxt = TIMER_W'(1);
                end
            end
            WAIT: begin
                if (hz.mem_ready_m) begin
                    // access completes this cycle; pipeline moves on
                    state_nxt = IDLE;
                end else begin
                    mem_stall = 1'b1;
                    if (timer == TIMEOUT_VAL) begin
                        state_nxt = ERR;
                    end else begin
                        timer_nxt = timer + TIMER_W'(1);
                    end
                end
            end
            ERR: begin
                // frozen until reset
                mem_stall = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Stage controls
    // ------------------------------------------------------------------
    // A taken branch squashes the D instruction, so its hazard stall is moot.
    assign front_stall = mem_stall || (hazard && !hz.pc_src_e);

    // Control outputs; a frozen M stage defers branch and bubble flushes
    always_comb begin
        hz.stall_f     = 1'b0;
        hz.stall_d     = 1'b0;
        hz.stall_e     = 1'b0;
        hz.stall_m     = 1'b0;
        hz.flush_d     = 1'b0;
        hz.flush_e     = 1'b0;
        hz.flush_w     = 1'b0;
        hz.forward_a_e = FWD_RF;
        hz.forward_b_e = FWD_RF;
        mem_timeout    = 1'b0;
        if (!rst) begin
            hz.stall_f     = front_stall;
            hz.stall_d     = front_stall;
            hz.stall_e     = mem_stall;
            hz.stall_m     = mem_stall;
            hz.flush_w     = mem_stall;
            hz.flush_d     = hz.pc_src_e && !mem_stall;
            hz.flush_e     = !mem_stall && (hz.pc_src_e || hazard);
            hz.forward_a_e = FWD_EN ? fwd_a : FWD_RF;
            hz.forward_b_e = FWD_EN ? fwd_b : FWD_RF;
            mem_timeout    = (state == ERR);
        end
    end

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
    // Saturating stall/flush cycle counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz.stall_f && (stall_cnt != CNT_MAX)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if ((hz.flush_d || hz.flush_e) && (flush_cnt != CNT_MAX)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Two instances share one
// stimulus: dut0 with forwarding and a short watchdog, dut1 without
// forwarding and with narrow counters so saturation is reachable.
module tb_pipeline_hazard_ctrl;

    localparam int AW  = 5;
    localparam int TO0 = 4;
    localparam int TO1 = 255;
    localparam int CW0 = 32;
    localparam int CW1 = 4;

    typedef struct packed {
        logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
        logic rs1_used_d, rs2_used_d, reg_write_e, reg_write_m, reg_write_w;
        logic mem_read_e, pc_src_e, mem_req_m, mem_ready_m;
    } stim_t;

    logic clk = 1'b0;
    logic rst;
    stim_t s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_AW(AW)) hz0 ();
    pipeline_hazard_ctrl_if #(.REG_AW(AW)) hz1 ();

    assign hz0.rs1_d = s.rs1_d;             assign hz1.rs1_d = s.rs1_d;
    assign hz0.rs2_d = s.rs2_d;             assign hz1.rs2_d = s.rs2_d;
    assign hz0.rs1_used_d = s.rs1_used_d;   assign hz1.rs1_used_d = s.rs1_used_d;
    assign hz0.rs2_used_d = s.rs2_used_d;   assign hz1.rs2_used_d = s.rs2_used_d;
    assign hz0.rs1_e = s.rs1_e;             assign hz1.rs1_e = s.rs1_e;
    assign hz0.rs2_e = s.rs2_e;             assign hz1.rs2_e = s.rs2_e;
    assign hz0.rd_e = s.rd_e;               assign hz1.rd_e = s.rd_e;
    assign hz0.rd_m = s.rd_m;               assign hz1.rd_m = s.rd_m;
    assign hz0.rd_w = s.rd_w;               assign hz1.rd_w = s.rd_w;
    assign hz0.reg_write_e = s.reg_write_e; assign hz1.reg_write_e = s.reg_write_e;
    assign hz0.reg_write_m = s.reg_write_m; assign hz1.reg_write_m = s.reg_write_m;
    assign hz0.reg_write_w = s.reg_write_w; assign hz1.reg_write_w = s.reg_write_w;
    assign hz0.mem_read_e = s.mem_read_e;   assign hz1.mem_read_e = s.mem_read_e;
    assign hz0.pc_src_e = s.pc_src_e;       assign hz1.pc_src_e = s.pc_src_e;
    assign hz0.mem_req_m = s.mem_req_m;     assign hz1.mem_req_m = s.mem_req_m;
    assign hz0.mem_ready_m = s.mem_ready_m; assign hz1.mem_ready_m = s.mem_ready_m;

    logic           mem_timeout0, mem_timeout1;
    logic [CW0-1:0] stall_cnt0, flush_cnt0;
    logic [CW1-1:0] stall_cnt1, flush_cnt1;

    pipeline_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b1), .MEM_TIMEOUT(TO0), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst(rst), .hz(hz0),
        .mem_timeout(mem_timeout0), .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0)
    );

    pipeline_hazard_ctrl #(.REG_AW(AW), .FWD_EN(1'b0), .MEM_TIMEOUT(TO1), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst(rst), .hz(hz1),
        .mem_timeout(mem_timeout1), .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    // Packed view {stall_f,stall_d,stall_e,stall_m,flush_d,flush_e,flush_w,fwd_a,fwd_b,mem_timeout}
    logic [11:0] got0, got1;
    assign got0 = {hz0.stall_f, hz0.stall_d, hz0.stall_e, hz0.stall_m, hz0.flush_d, hz0.flush_e,
                   hz0.flush_w, hz0.forward_a_e, hz0.forward_b_e, mem_timeout0};
    assign got1 = {hz1.stall_f, hz1.stall_d, hz1.stall_e, hz1.stall_m, hz1.flush_d, hz1.flush_e,
                   hz1.flush_w, hz1.forward_a_e, hz1.forward_b_e, mem_timeout1};

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [1:0] fwd_model(input bit en, input logic [AW-1:0] src, input stim_t v);
        if (!en || src == '0) return 2'b00;
        if (v.reg_write_m && v.rd_m == src) return 2'b10;
        if (v.reg_write_w && v.rd_w == src) return 2'b01;
        return 2'b00;
    endfunction

    // streak = consecutive memory-busy cycles so far; err = watchdog fired
    function automatic logic [11:0] model_ctrl(input stim_t v, input logic r, input int streak,
                                               input bit err, input bit fwd_en);
        logic [AW-1:0] stage_rd [3];
        logic          stage_we [3];
        logic busy, lu, raw, hzd, sfd, fd, fe;
        if (r) return '0;
        busy = err || ((streak > 0) ? !v.mem_ready_m : (v.mem_req_m && !v.mem_ready_m));
        stage_rd = '{v.rd_e, v.rd_m, v.rd_w};
        stage_we = '{v.reg_write_e, v.reg_write_m, v.reg_write_w};
        raw = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (stage_we[k] && stage_rd[k] != '0 &&
                ((v.rs1_used_d && v.rs1_d == stage_rd[k]) || (v.rs2_used_d && v.rs2_d == stage_rd[k])))
                raw = 1'b1;
        end
        lu  = v.mem_read_e && v.reg_write_e && v.rd_e != '0 &&
              ((v.rs1_used_d && v.rs1_d == v.rd_e) || (v.rs2_used_d && v.rs2_d == v.rd_e));
        hzd = fwd_en ? lu : raw;
        sfd = busy || (hzd && !v.pc_src_e);
        fd  = v.pc_src_e && !busy;
        fe  = !busy && (v.pc_src_e || hzd);
        return {sfd, sfd, busy, busy, fd, fe, busy,
                fwd_model(fwd_en, v.rs1_e, v), fwd_model(fwd_en, v.rs2_e, v), logic'(err)};
    endfunction

    int streak0 = 0, streak1 = 0;
    bit err0 = 1'b0, err1 = 1'b0;
    logic [CW0-1:0] sc0, fc0;
    logic [CW1-1:0] sc1, fc1;
    logic [11:0] exp0, exp1;

    always_comb exp0 = model_ctrl(s, rst, streak0, err0, 1'b1);
    always_comb exp1 = model_ctrl(s, rst, streak1, err1, 1'b0);

    always @(posedge clk) begin
        if (rst) begin
            streak0 = 0; err0 = 1'b0; sc0 = '0; fc0 = '0;
            streak1 = 0; err1 = 1'b0; sc1 = '0; fc1 = '0;
        end else begin
            if (exp0[11] && sc0 != '1) sc0 = sc0 + 1'b1;
            if ((exp0[7] || exp0[6]) && fc0 != '1) fc0 = fc0 + 1'b1;
            if (exp1[11] && sc1 != '1) sc1 = sc1 + 1'b1;
            if ((exp1[7] || exp1[6]) && fc1 != '1) fc1 = fc1 + 1'b1;
            if (!err0) begin
                streak0 = exp0[8] ? streak0 + 1 : 0;
                if (streak0 > TO0) err0 = 1'b1;
            end
            if (!err1) begin
                streak1 = exp1[8] ? streak1 + 1 : 0;
                if (streak1 > TO1) err1 = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Sequencing helpers
    // ------------------------------------------------------------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s   = '0;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic set_load_use();
        s.rd_e = 5'd6; s.reg_write_e = 1'b1; s.mem_read_e = 1'b1;
        s.rs2_d = 5'd6; s.rs2_used_d = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        s = '0;
        s.mem_req_m = 1'b1; s.pc_src_e = 1'b1; s.reg_write_m = 1'b1; s.rd_m = 5'd3; s.rs1_e = 5'd3;
        set_load_use();
        for (int i = 0; i < 3; i++) begin
            settle();
            n_checks += 2;
            if (got0 !== 12'h000) begin n_fail++; $display("FAIL reset_dut0 cyc%0d got=%h exp=000", i, got0); end
            if (got1 !== 12'h000) begin n_fail++; $display("FAIL reset_dut1 cyc%0d got=%h exp=000", i, got1); end
            next_cycle();
        end
        rst = 1'b0;
        s = '0;
        settle();
        n_checks += 4;
        if (got0 !== 12'h000) begin n_fail++; $display("FAIL reset_idle got=%h exp=000", got0); end
        if (stall_cnt0 !== '0) begin n_fail++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt0); end
        if (flush_cnt0 !== '0) begin n_fail++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt0); end
        if (stall_cnt1 !== '0) begin n_fail++; $display("FAIL reset_stall_cnt1 got=%0d exp=0", stall_cnt1); end
        next_cycle();
    endtask

    task automatic test_forwarding();
        // rd_m, we_m, rd_w, we_w, rs1_e, rs2_e, exp_a, exp_b
        int t [6][8] = '{'{5, 1, 0, 0, 5, 1, 2, 0},
                         '{5, 1, 5, 1, 5, 5, 2, 2},
                         '{0, 1, 0, 1, 0, 0, 0, 0},
                         '{3, 1, 9, 1, 9, 3, 1, 2},
                         '{5, 0, 5, 1, 5, 6, 1, 0},
                         '{7, 1, 8, 0, 8, 7, 0, 2}};
        for (int i = 0; i < 6; i++) begin
            s = '0;
            s.rd_m = AW'(t[i][0]); s.reg_write_m = 1'(t[i][1]);
            s.rd_w = AW'(t[i][2]); s.reg_write_w = 1'(t[i][3]);
            s.rs1_e = AW'(t[i][4]); s.rs2_e = AW'(t[i][5]);
            settle();
            n_checks += 4;
            if (hz0.forward_a_e !== 2'(t[i][6]))
                begin n_fail++; $display("FAIL fwd_a case%0d got=%b exp=%b", i, hz0.forward_a_e, 2'(t[i][6])); end
            if (hz0.forward_b_e !== 2'(t[i][7]))
                begin n_fail++; $display("FAIL fwd_b case%0d got=%b exp=%b", i, hz0.forward_b_e, 2'(t[i][7])); end
            if (got0[11:5] !== 7'b0)
                begin n_fail++; $display("FAIL fwd_no_stall case%0d got=%b exp=0", i, got0[11:5]); end
            if (got1 !== 12'h000)
                begin n_fail++; $display("FAIL fwd_off_dut1 case%0d got=%h exp=000", i, got1); end
            next_cycle();
        end
    endtask

    task automatic test_load_use();
        // rd_e, we_e, mem_read_e, rs1_d, used1, rs2_d, used2, exp dut0
        int t [6][8] = '{'{6, 1, 1, 2, 1, 6, 1, 'hC40},
                         '{6, 1, 1, 2, 1, 6, 0, 'h000},
                         '{0, 1, 1, 0, 1, 0, 1, 'h000},
                         '{6, 1, 0, 0, 0, 6, 1, 'h000},
                         '{6, 1, 1, 6, 1, 3, 0, 'hC40},
                         '{0, 0, 0, 0, 0, 0, 0, 'h000}};
        for (int i = 0; i < 6; i++) begin
            s = '0;
            s.rd_e = AW'(t[i][0]); s.reg_write_e = 1'(t[i][1]); s.mem_read_e = 1'(t[i][2]);
            s.rs1_d = AW'(t[i][3]); s.rs1_used_d = 1'(t[i][4]);
            s.rs2_d = AW'(t[i][5]); s.rs2_used_d = 1'(t[i][6]);
            settle();
            n_checks++;
            if (got0 !== 12'(t[i][7]))
                begin n_fail++; $display("FAIL load_use case%0d got=%h exp=%h", i, got0, 12'(t[i][7])); end
            next_cycle();
        end
    endtask

    task automatic test_mem_wait();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            logic [11:0] e;
            s = '0;
            s.mem_req_m   = (i < 4);
            s.mem_ready_m = (i >= 3);
            e = (i < 3) ? 12'hF20 : 12'h000;
            settle();
            n_checks += 2;
            if (got0 !== e) begin n_fail++; $display("FAIL mem_wait_dut0 cyc%0d got=%h exp=%h", i, got0, e); end
            if (got1 !== e) begin n_fail++; $display("FAIL mem_wait_dut1 cyc%0d got=%h exp=%h", i, got1, e); end
            next_cycle();
        end
        settle();
        n_checks += 3;
        if (stall_cnt0 !== 32'd3) begin n_fail++; $display("FAIL mem_wait_stall_cnt got=%0d exp=3", stall_cnt0); end
        if (flush_cnt0 !== 32'd0) begin n_fail++; $display("FAIL mem_wait_flush_cnt got=%0d exp=0", flush_cnt0); end
        if (stall_cnt1 !== 4'd3)  begin n_fail++; $display("FAIL mem_wait_stall_cnt1 got=%0d exp=3", stall_cnt1); end
        next_cycle();
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            logic [11:0] e;
            s = '0;
            s.mem_req_m   = (i < 7);
            s.mem_ready_m = (i == 7);
            e = (i < 5) ? 12'hF20 : 12'hF21;
            settle();
            n_checks++;
            if (got0 !== e) begin n_fail++; $display("FAIL timeout cyc%0d got=%h exp=%h", i, got0, e); end
            next_cycle();
        end
        rst = 1'b1;
        settle();
        n_checks++;
        if (got0 !== 12'h000) begin n_fail++; $display("FAIL timeout_in_rst got=%h exp=000", got0); end
        next_cycle();
        rst = 1'b0;
        s = '0;
        settle();
        n_checks += 2;
        if (got0 !== 12'h000) begin n_fail++; $display("FAIL timeout_after_rst got=%h exp=000", got0); end
        if (stall_cnt0 !== '0) begin n_fail++; $display("FAIL timeout_cnt_clr got=%0d exp=0", stall_cnt0); end
        next_cycle();
    endtask

    task automatic test_branch_mem();
        // mem_req, mem_ready, pc_src_e, load_use, exp dut0
        int t [8][5] = '{'{1, 0, 1, 0, 'hF20},
                         '{1, 0, 1, 0, 'hF20},
                         '{1, 1, 1, 0, 'h0C0},
                         '{0, 0, 0, 0, 'h000},
                         '{0, 0, 1, 1, 'h0C0},
                         '{1, 0, 0, 1, 'hF20},
                         '{1, 1, 0, 1, 'hC40},
                         '{0, 0, 0, 0, 'h000}};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            s = '0;
            if (t[i][3] != 0) set_load_use();
            s.mem_req_m = 1'(t[i][0]); s.mem_ready_m = 1'(t[i][1]); s.pc_src_e = 1'(t[i][2]);
            settle();
            n_checks++;
            if (got0 !== 12'(t[i][4]))
                begin n_fail++; $display("FAIL branch_mem cyc%0d got=%h exp=%h", i, got0, 12'(t[i][4])); end
            next_cycle();
        end
        settle();
        n_checks += 2;
        if (stall_cnt0 !== 32'd4) begin n_fail++; $display("FAIL branch_mem_stall_cnt got=%0d exp=4", stall_cnt0); end
        if (flush_cnt0 !== 32'd3) begin n_fail++; $display("FAIL branch_mem_flush_cnt got=%0d exp=3", flush_cnt0); end
        next_cycle();
    endtask

    task automatic test_no_fwd();
        // add x7 walks E -> M -> W while D reads x7 through rs1
        logic [11:0] e0 [4] = '{12'h000, 12'h010, 12'h008, 12'h000};
        logic [11:0] e1 [4] = '{12'hC40, 12'hC40, 12'hC40, 12'h000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            s = '0;
            s.rs1_d = 5'd7; s.rs1_used_d = 1'b1; s.rs1_e = 5'd7;
            if (i == 0) begin s.rd_e = 5'd7; s.reg_write_e = 1'b1; end
            if (i == 1) begin s.rd_m = 5'd7; s.reg_write_m = 1'b1; end
            if (i == 2) begin s.rd_w = 5'd7; s.reg_write_w = 1'b1; end
            settle();
            n_checks += 2;
            if (got1 !== e1[i]) begin n_fail++; $display("FAIL no_fwd_dut1 cyc%0d got=%h exp=%h", i, got1, e1[i]); end
            if (got0 !== e0[i]) begin n_fail++; $display("FAIL no_fwd_dut0 cyc%0d got=%h exp=%h", i, got0, e0[i]); end
            next_cycle();
        end
        // hold the RAW hazard long enough to saturate the 4-bit counters
        s = '0;
        s.rs1_d = 5'd7; s.rs1_used_d = 1'b1; s.rd_e = 5'd7; s.reg_write_e = 1'b1;
        for (int i = 0; i < 20; i++) next_cycle();
        s = '0;
        settle();
        n_checks += 3;
        if (stall_cnt1 !== 4'hF) begin n_fail++; $display("FAIL sat_stall_cnt1 got=%0d exp=15", stall_cnt1); end
        if (flush_cnt1 !== 4'hF) begin n_fail++; $display("FAIL sat_flush_cnt1 got=%0d exp=15", flush_cnt1); end
        if (stall_cnt0 !== 32'd0) begin n_fail++; $display("FAIL no_fwd_stall_cnt0 got=%0d exp=0", stall_cnt0); end
        next_cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            int ready_pct;
            ready_pct = ((i % 200) < 100) ? 70 : 15;
            s.rs1_d = AW'($urandom_range(0, 3));  s.rs2_d = AW'($urandom_range(0, 3));
            s.rs1_e = AW'($urandom_range(0, 3));  s.rs2_e = AW'($urandom_range(0, 3));
            s.rd_e  = AW'($urandom_range(0, 3));  s.rd_m  = AW'($urandom_range(0, 3));
            s.rd_w  = AW'($urandom_range(0, 3));
            s.rs1_used_d  = 1'($urandom);  s.rs2_used_d  = 1'($urandom);
            s.reg_write_e = 1'($urandom);  s.reg_write_m = 1'($urandom);
            s.reg_write_w = 1'($urandom);  s.mem_read_e  = 1'($urandom);
            s.pc_src_e    = ($urandom_range(0, 3) == 0);
            s.mem_req_m   = 1'($urandom);
            s.mem_ready_m = ($urandom_range(0, 99) < ready_pct);
            rst           = ($urandom_range(0, 79) == 0);
            settle();
            n_checks += 6;
            if (got0 !== exp0) begin n_fail++; $display("FAIL rand_dut0 cyc%0d got=%h exp=%h", i, got0, exp0); end
            if (got1 !== exp1) begin n_fail++; $display("FAIL rand_dut1 cyc%0d got=%h exp=%h", i, got1, exp1); end
            if (stall_cnt0 !== sc0) begin n_fail++; $display("FAIL rand_stall_cnt0 cyc%0d got=%0d exp=%0d", i, stall_cnt0, sc0); end
            if (flush_cnt0 !== fc0) begin n_fail++; $display("FAIL rand_flush_cnt0 cyc%0d got=%0d exp=%0d", i, flush_cnt0, fc0); end
            if (stall_cnt1 !== sc1) begin n_fail++; $display("FAIL rand_stall_cnt1 cyc%0d got=%0d exp=%0d", i, stall_cnt1, sc1); end
            if (flush_cnt1 !== fc1) begin n_fail++; $display("FAIL rand_flush_cnt1 cyc%0d got=%0d exp=%0d", i, flush_cnt1, fc1); end
            next_cycle();
        end
        rst = 1'b0;
        s   = '0;
    endtask

    // ------------------------------------------------------------------
    // Sequence and watchdog
    // ------------------------------------------------------------------
    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_branch_mem();
        test_no_fwd();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "simulation time limit");
    end

endmodule
